tlb_op_unit: RTL
================

// Module: tlb_op_unit
// PURPOSE
//  Sequencer for the CP0 TLB instructions TLBP, TLBR, TLBWI and TLBWR; sits directly upstream of the TLB array.
//  Drives the TLB's vAddr/index/re/we, owns the Random register and returns probe/read results to CP0.
//  The decode stage issues one op and stalls on busy; done tells the pipeline the op has completed.
// PARAMETERS
//  ENTRY_ADDR_WIDTH  3  log2 of TLB entry count; must match the TLB instance. COUNT = 1<<ENTRY_ADDR_WIDTH.
// PORTS
//  clk              in   1   clock, all state on rising edge
//  res              in   1   asynchronous reset, active-high
//  opValid          in   1   op request; accepted only when busy==0
//  op               in   3   0 NOP, 1 TLBP, 2 TLBR, 3 TLBWI, 4 TLBWR; 5-7 illegal
//  busy             out  1   op in flight (state!=IDLE)
//  done             out  1   one-cycle completion pulse
//  cp0EntryHi       in   32  CP0 EntryHi (VPN2 [31:13], ASID [7:0])
//  cp0Index         in   32  CP0 Index
//  cp0Wired         in   32  CP0 Wired (unsigned)
//  wiredWe          in   1   CP0 is writing Wired this cycle
//  random           out  32  Random register, zero-extended
//  tlbVAddr         out  32  to TLB vAddr
//  tlbIndex         out  32  to TLB index, zero-extended
//  tlbRe            out  1   to TLB re
//  tlbWe            out  1   to TLB we
//  tlbFound         in   1   from TLB found
//  tlbMatchedIndex  in   32  from TLB matchedIndex
//  indexWe          out  1   CP0 Index write strobe (TLBP result)
//  indexOut         out  32  TLBP result: hit {1'b0,0..,idx}; miss 32'h8000_0000
//  entryWe          out  1   CP0 strobe: latch TLB entryHi/Lo0/Lo1/pageMask outputs (TLBR)
// BEHAVIOUR
//  Reset: state IDLE; busy, done, tlbRe, tlbWe, indexWe, entryWe = 0; random = COUNT-1; tlbIndex = 0; tlbVAddr = 0.
//  FSM: IDLE -> EXEC -> DONE -> IDLE. All strobes are combinational decodes of the registered state/op.
//  - IDLE: on opValid with legal non-NOP op, register op and randSnap <= random, then go to EXEC.
//    NOP and illegal ops are ignored: no busy, no done.
//  - EXEC (1 cycle):
//    TLBP: tlbVAddr = {cp0EntryHi[31:13],13'b0}; tlbRe = 0; indexWe = 1; indexOut from tlbFound/tlbMatchedIndex.
//    TLBR: tlbRe = 1; tlbIndex = cp0Index[ENTRY_ADDR_WIDTH-1:0]; entryWe = 1 (TLB read is combinational).
//    TLBWI: tlbWe = 1; tlbIndex = cp0Index[ENTRY_ADDR_WIDTH-1:0]; upper Index bits are ignored (truncated).
//    TLBWR: tlbWe = 1; tlbIndex = randSnap.
//  - DONE: done = 1, busy still 1; next cycle IDLE.
//  - Latency: op accepted at edge N; EXEC strobes during cycle N+1; done during N+2; next op accepted at N+3.
//  - Outside EXEC: all strobes 0; tlbIndex = 0; tlbVAddr = 0.
//  Random update, every cycle, including while busy:
//    if (wiredWe || random <= cp0Wired) random <= COUNT-1; else random <= random-1.
//    Random therefore cycles COUNT-1 down to Wired, inclusive.
//    If Wired >= COUNT-1, Random holds at COUNT-1.
//    Comparison is 32-bit unsigned with random zero-extended.
//  Simultaneous events:
//    TLBWR accepted in the same cycle as wiredWe: snapshot takes the pre-update random.
//    opValid while busy: ignored; the requester must hold it.
//  Reset mid-op: returns to IDLE immediately; no strobes; the pending write is dropped.
// TESTING
//  1 Reset, ENTRY_ADDR_WIDTH=3, Wired=5 -> random 7,6,5,7,6,5...; all strobes 0.
//  2 wiredWe pulse while random=5 (Wired=2) -> next random 7, then 6,5,4,3,2,7.
//  3 TLBP, EntryHi=0x0040_2011, TLB hit at 3 -> cycle N+1: indexWe=1, indexOut=0x3, tlbVAddr=0x0040_2000; done at N+2.
//    TLBP miss -> indexOut=0x8000_0000.
//  4 TLBWI, cp0Index=0x0000_000A -> tlbWe=1 for exactly one cycle, tlbIndex=2.
//    TLBR, Index=6 -> tlbRe=1, entryWe=1, tlbIndex=6.
//  5 TLBWR accepted when random=4, concurrent wiredWe -> tlbIndex=4; random then 7.
//    opValid held high gives back-to-back ops accepted every 3 cycles.
//  6 res asserted during EXEC of TLBWI -> tlbWe drops asynchronously, no done, random=7.
//    op=6 -> busy stays 0.

Source files
------------

// File: rtl/tlb_op_unit.sv
// rtl/tlb_op_unit.sv - CP0 TLB instruction sequencer (TLBP/TLBR/TLBWI/TLBWR) and Random register
module tlb_op_unit #(
  parameter int ENTRY_ADDR_WIDTH = 3
) (
  input  logic        clk,
  input  logic        res,
  input  logic        opValid,
  input  logic [2:0]  op,
  output logic        busy,
  output logic        done,
  input  logic [31:0] cp0EntryHi,
  input  logic [31:0] cp0Index,
  input  logic [31:0] cp0Wired,
  input  logic        wiredWe,
  output logic [31:0] random,
  output logic [31:0] tlbVAddr,
  output logic [31:0] tlbIndex,
  output logic        tlbRe,
  output logic        tlbWe,
  input  logic        tlbFound,
  input  logic [31:0] tlbMatchedIndex,
  output logic        indexWe,
  output logic [31:0] indexOut,
  output logic        entryWe
);

  localparam int AW = ENTRY_ADDR_WIDTH;
  localparam logic [AW-1:0] RAND_TOP = {AW{1'b1}};

  localparam logic [2:0] OP_TLBP  = 3'd1;
  localparam logic [2:0] OP_TLBR  = 3'd2;
  localparam logic [2:0] OP_TLBWI = 3'd3;
  localparam logic [2:0] OP_TLBWR = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [AW-1:0]   rand_snap_q, rand_snap_d;
  logic [AW-1:0]   random_q, random_d;
  logic            accept;
  logic            unused_bits;

  assign unused_bits = ^{cp0EntryHi[12:0], cp0Index[31:AW], tlbMatchedIndex[31:AW]};

  assign accept = (state_q == ST_IDLE) && opValid && (op >= OP_TLBP) && (op <= OP_TLBWR);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= ST_IDLE;
      op_q        <= 3'd0;
      rand_snap_q <= RAND_TOP;
      random_q    <= RAND_TOP;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rand_snap_q <= rand_snap_d;
      random_q    <= random_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_EXEC;
      ST_EXEC: state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Op and snapshot are captured only on acceptance; the snapshot sees pre-update Random.
  always_comb begin
    op_d        = op_q;
    rand_snap_d = rand_snap_q;
    if (accept) begin
      op_d        = op;
      rand_snap_d = random_q;
    end
  end

  always_comb begin
    random_d = random_q - 1'b1;
    if (wiredWe || ({{(32-AW){1'b0}}, random_q} <= cp0Wired)) begin
      random_d = RAND_TOP;
    end
  end

  always_comb begin
    busy     = (state_q != ST_IDLE);
    done     = (state_q == ST_DONE);
    random   = {{(32-AW){1'b0}}, random_q};
    tlbVAddr = 32'd0;
    tlbIndex = 32'd0;
    tlbRe    = 1'b0;
    tlbWe    = 1'b0;
    indexWe  = 1'b0;
    indexOut = 32'd0;
    entryWe  = 1'b0;
    if (state_q == ST_EXEC) begin
      case (op_q)
        OP_TLBP: begin
          tlbVAddr = {cp0EntryHi[31:13], 13'd0};
          indexWe  = 1'b1;
          indexOut = tlbFound ? {{(32-AW){1'b0}}, tlbMatchedIndex[AW-1:0]} : 32'h8000_0000;
        end
        OP_TLBR: begin
          tlbRe    = 1'b1;
          tlbIndex = {{(32-AW){1'b0}}, cp0Index[AW-1:0]};
          entryWe  = 1'b1;
        end
        OP_TLBWI: begin
          tlbWe    = 1'b1;
          tlbIndex = {{(32-AW){1'b0}}, cp0Index[AW-1:0]};
        end
        OP_TLBWR: begin
          tlbWe    = 1'b1;
          tlbIndex = {{(32-AW){1'b0}}, rand_snap_q};
        end
        default: ;
      endcase
    end
  end

endmodule
